// File: rtl/bexkat1Def.sv
// Shared definitions for the interrupt controller: register word indices,
// controller state encoding and the highest-set-bit helpers.
// Pure declarations, no logic or latency of its own.
package bexkat1Def;

   localparam int INTC_NSRC = 7;

   // Register word indices on the adr_i bus
   localparam logic [1:0] INTC_PENDING = 2'd0;
   localparam logic [1:0] INTC_MASK    = 2'd1;
   localparam logic [1:0] INTC_EDGE    = 2'd2;
   localparam logic [1:0] INTC_ISR     = 2'd3;

   // Controller state as seen from outside:
   //   IDLE  - nothing in service, nothing requested
   //   REQ   - a code is being presented on interrupts_o
   //   INSVC - at least one source in service, nothing higher requested
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_INSVC = 2'd2
   } intc_state_t;

   // Code (bit index + 1) of the highest set bit, 0 when no bit is set.
   // Source 6 is the highest priority and maps to code 7.
   function automatic logic [2:0] intc_top_code(input logic [INTC_NSRC-1:0] v);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < INTC_NSRC; i++) begin
         if (v[i]) c = 3'(i + 1);
      end
      return c;
   endfunction

   // Sources whose code is strictly greater than 'code': bits [6:code].
   function automatic logic [INTC_NSRC-1:0] intc_above(input logic [2:0] code);
      return 7'h7f << code;
   endfunction

endpackage

// File: rtl/int_prio_enc.sv
// 7-to-3 priority encoder: code of the highest set request bit, 0 = none.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module int_prio_enc
   import bexkat1Def::*;
(
   input  logic [INTC_NSRC-1:0] req,
   output logic [2:0]           code
);

   // Highest set bit wins; bit n reports code n+1
   always_comb begin
      code = intc_top_code(req);
   end

endmodule

// File: rtl/int_ctrl.sv
// Seven-source nesting interrupt controller with a small register bus.
// Latency: irq_i rise to interrupts_o is 3 cycles (2-flop sync + output reg); bus ack 1 cycle.
// Backpressure: bus requests are not accepted while ack_o is high. Macro INT_CTRL_EDGE_EN enables edge-triggered sources.
module int_ctrl
   import bexkat1Def::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [6:0]  irq_i,
   output logic [2:0]  interrupts_o,
   input  logic        interrupts_enabled_i,
   input  logic        exc_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [1:0]  adr_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o
);

   logic [6:0]  sync1_q;
   logic [6:0]  sync2_q;
   logic [6:0]  mask_q;
   logic [6:0]  isr_q;
   logic [2:0]  prev_code_q;
   intc_state_t st_q;
   intc_state_t st_nxt;

   logic        bus_acc;
   logic        bus_wr;
   logic [6:0]  wdat;
   logic        unused_dat;

   logic        ack_hit;
   logic [6:0]  ack_bit;
   logic [6:0]  isr_acked;
   logic [2:0]  isr_top_code;
   logic [6:0]  isr_top_bit;
   logic [6:0]  isr_nxt;

   logic [6:0]  edge_vis;
   logic [6:0]  pend_vis;
   logic [6:0]  pend_elig;
   logic [6:0]  eligible;
   logic [2:0]  elig_code;
   logic [31:0] rd_dat;

   assign bus_acc    = cyc_i & stb_i & ~ack_o;
   assign bus_wr     = bus_acc & we_i;
   assign wdat       = dat_i[6:0];
   assign unused_dat = ^dat_i[31:7];

   // The pipeline takes an interrupt when it raises exc_i one cycle after it
   // saw a nonzero code with interrupts enabled; prev_code_q holds that code.
   assign ack_hit = exc_i & (prev_code_q != 3'd0);

   // One-hot ISR bit of the source being acknowledged
   always_comb begin
      ack_bit = '0;
      if (ack_hit) ack_bit[prev_code_q - 3'd1] = 1'b1;
   end

   // Ack is applied before EOI so a same-cycle EOI can retire the code just taken
   assign isr_acked = isr_q | ack_bit;

   int_prio_enc u_isr_enc (
      .req  (isr_acked),
      .code (isr_top_code)
   );

   // One-hot of the highest in-service bit, the one an EOI retires
   always_comb begin
      isr_top_bit = '0;
      if (isr_top_code != 3'd0) isr_top_bit[isr_top_code - 3'd1] = 1'b1;
   end

   assign isr_nxt = (bus_wr && adr_i == INTC_ISR) ? (isr_acked & ~isr_top_bit) : isr_acked;

`ifdef INT_CTRL_EDGE_EN
   logic [6:0] sync3_q;
   logic [6:0] edge_q;
   logic [6:0] pend_q;
   logic [6:0] rise;
   logic [6:0] w1c;
   logic [6:0] pend_nxt;

   assign rise = sync2_q & ~sync3_q;
   assign w1c  = (bus_wr && adr_i == INTC_PENDING) ? wdat : 7'd0;

   // A new rising edge outranks both the ack clear and a W1C clear
   assign pend_nxt = ((pend_q & ~ack_bit & ~w1c) | rise) & edge_q;

   // Edge-mode configuration, edge detector history and latched pending bits
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync3_q <= '0;
         edge_q  <= '0;
         pend_q  <= '0;
      end else begin
         sync3_q <= sync2_q;
         pend_q  <= pend_nxt;
         if (bus_wr && adr_i == INTC_EDGE) edge_q <= wdat;
      end
   end

   assign edge_vis  = edge_q;
   assign pend_vis  = (sync2_q & ~edge_q) | (pend_q & edge_q);
   assign pend_elig = (sync2_q & ~edge_q) | pend_nxt;
`else
   // Level-only build: PENDING is the synchronized request, EDGE reads 0
   assign edge_vis  = '0;
   assign pend_vis  = sync2_q;
   assign pend_elig = sync2_q;
`endif

   // Only sources above the most important code still in service may request
   assign eligible = pend_elig & mask_q & intc_above(intc_top_code(isr_nxt));

   int_prio_enc u_elig_enc (
      .req  (eligible),
      .code (elig_code)
   );

   // Next controller state follows directly from the next code and ISR
   always_comb begin
      st_nxt = ST_IDLE;
      if (elig_code != 3'd0)  st_nxt = ST_REQ;
      else if (isr_nxt != '0) st_nxt = ST_INSVC;
   end

   // Register read mux; unused upper bits read as zero
   always_comb begin
      rd_dat = '0;
      case (adr_i)
         INTC_PENDING: rd_dat[6:0] = pend_vis;
         INTC_MASK:    rd_dat[6:0] = mask_q;
         INTC_EDGE:    rd_dat[6:0] = edge_vis;
         INTC_ISR:     rd_dat[6:0] = isr_q;
         default:      rd_dat      = '0;
      endcase
   end

   // Two-flop synchronizer on each device request
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irq_i;
         sync2_q <= sync1_q;
      end
   end

   // Bus acknowledge, read data and MASK register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_o  <= 1'b0;
         dat_o  <= '0;
         mask_q <= '0;
      end else begin
         ack_o <= bus_acc;
         dat_o <= bus_acc ? rd_dat : 32'd0;
         if (bus_wr && adr_i == INTC_MASK) mask_q <= wdat;
      end
   end

   // Controller state machine: presented code, in-service set and ack capture
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         st_q         <= ST_IDLE;
         interrupts_o <= 3'd0;
         isr_q        <= '0;
         prev_code_q  <= 3'd0;
      end else begin
         st_q         <= st_nxt;
         interrupts_o <= elig_code;
         isr_q        <= isr_nxt;
         // st_q is ST_REQ exactly when interrupts_o is nonzero this cycle
         prev_code_q  <= (st_q == ST_REQ && interrupts_enabled_i) ? interrupts_o : 3'd0;
      end
   end

endmodule
